// File: rtl/sng_corr_pair.sv
// sng_corr_pair: correlated stochastic number generator.
// Two BW-bit binaries are turned into two unipolar bitstreams of length
// 2^BW-1. Both streams compare against one shared LFSR sequence, so the
// pair is maximally positively correlated (SCC = +1).
module sng_corr_pair #(
  parameter int              BW   = 8,
  parameter logic [BW-1:0]   SEED = {{(BW-1){1'b0}}, 1'b1}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_a,
  input  logic [BW-1:0] in_b,
  input  logic          out_en,
  output logic          out_valid,
  output logic          out_a,
  output logic          out_b,
  output logic          done
);

  // Feedback tap masks, bit index = polynomial exponent - 1.
  localparam logic [15:0] TAP_ALL =
      (BW == 4)  ? 16'h000C :   // x^4+x^3+1
      (BW == 8)  ? 16'h00B8 :   // x^8+x^6+x^5+x^4+1
      (BW == 10) ? 16'h0240 :   // x^10+x^7+1
      (BW == 12) ? 16'h0829 :   // x^12+x^6+x^4+x+1
                   16'hD008;    // x^16+x^15+x^13+x^4+1
  localparam logic [BW-1:0] TAPS = TAP_ALL[BW-1:0];

  // Index of the final bit of a stream (stream length is 2^BW-1).
  localparam logic [BW-1:0] LAST = {{(BW-1){1'b1}}, 1'b0};

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  generate
    if (!(BW == 4 || BW == 8 || BW == 10 || BW == 12 || BW == 16)) begin : g_bad_bw
      $error("sng_corr_pair: BW must be one of 4, 8, 10, 12, 16");
    end
    if (SEED == '0) begin : g_bad_seed
      $error("sng_corr_pair: SEED must be nonzero");
    end
  endgenerate

  logic [0:0]    state;
  logic [BW-1:0] lfsr;
  logic [BW-1:0] a_reg;
  logic [BW-1:0] b_reg;
  logic [BW-1:0] cnt;
  logic          fb;

  assign fb       = ^(lfsr & TAPS);
  assign in_ready = (state == IDLE);

  // Load operands in IDLE, then emit one comparison bit per enabled cycle
  // until the full LFSR period has been covered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= SEED;
      a_reg     <= '0;
      b_reg     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_a     <= 1'b0;
      out_b     <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          done      <= 1'b0;
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
            lfsr  <= SEED;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (out_en) begin
            out_a     <= (a_reg >= lfsr);
            out_b     <= (b_reg >= lfsr);
            out_valid <= 1'b1;
            lfsr      <= {lfsr[BW-2:0], fb};
            if (cnt == LAST) begin
              cnt   <= '0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              cnt  <= cnt + 1'b1;
              done <= 1'b0;
            end
          end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sng_corr_pair.sv
// Testbench for sng_corr_pair: scoreboard of expected stream bits built
// from the LFSR polynomial, checked by an independent monitor.
module tb_sng_corr_pair;

  localparam int LEN = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_a = 8'd0;
  logic [7:0] in_b = 8'd0;
  logic       out_en = 1'b1;
  logic       in_ready, out_valid, out_a, out_b, done;

  logic       v4_valid = 1'b0;
  logic [3:0] a4 = 4'd0;
  logic [3:0] b4 = 4'd0;
  logic       ready4, ov4, oa4, ob4, done4;

  typedef struct { logic a; logic b; logic last; } exp_t;
  typedef struct { int a; int b; } desc_t;

  exp_t  exp_q[$];
  desc_t desc_q[$];
  int    seq[LEN];

  int  tests = 0;
  int  fails = 0;
  int  valid_count = 0;
  int  ones_a = 0;
  int  ones_b = 0;
  bit  gap_pending = 1'b0;
  int  gap_cnt = 0;
  int  last_gap = -1;
  bit  stall_mode = 1'b0;

  always #5 clk = ~clk;

  sng_corr_pair #(.BW(8), .SEED(8'd1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_en(out_en), .out_valid(out_valid),
    .out_a(out_a), .out_b(out_b), .done(done)
  );

  sng_corr_pair #(.BW(4), .SEED(4'd1)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4_valid), .in_ready(ready4),
    .in_a(a4), .in_b(b4), .out_en(1'b1), .out_valid(ov4),
    .out_a(oa4), .out_b(ob4), .done(done4)
  );

  task automatic check_output(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: LFSR with x^8+x^6+x^5+x^4+1 started at 1.
  function automatic int next_lfsr(input int x);
    int fb;
    fb = ((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1;
    return ((x << 1) & 8'hFF) | fb;
  endfunction

  task automatic push_stream(input int a, input int b);
    exp_t  e;
    desc_t d;
    for (int i = 0; i < LEN; i++) begin
      e.a    = (a >= seq[i]);
      e.b    = (b >= seq[i]);
      e.last = (i == LEN - 1);
      exp_q.push_back(e);
    end
    d.a = a;
    d.b = b;
    desc_q.push_back(d);
  endtask

  // Offer a stream; returns at the negedge after it has been accepted.
  task automatic apply_stimulus(input int a, input int b);
    int n;
    in_valid = 1'b1;
    in_a = a[7:0];
    in_b = b[7:0];
    n = 0;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_output("accept_timeout", 0, 1);
    push_stream(a, b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check_output("drain_timeout", exp_q.size(), 0);
  endtask

  // Downstream enable: always on, or randomly toggling when stalling.
  initial begin
    forever begin
      @(negedge clk);
      out_en = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: pop one expectation per valid bit and compare.
  always @(negedge clk) begin
    exp_t  e;
    desc_t d;
    if (rst_n) begin
      if (out_valid) begin
        valid_count++;
        if (gap_pending) begin
          last_gap    = gap_cnt;
          gap_pending = 1'b0;
        end
        if (exp_q.size() == 0) begin
          check_output("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_output("out_a", out_a, e.a);
          check_output("out_b", out_b, e.b);
          check_output("done", done, e.last);
          ones_a += out_a;
          ones_b += out_b;
          if (e.last) begin
            if (desc_q.size() != 0) begin
              d = desc_q.pop_front();
              check_output("ones_a", ones_a, d.a);
              check_output("ones_b", ones_b, d.b);
            end
            ones_a      = 0;
            ones_b      = 0;
            gap_pending = 1'b1;
            gap_cnt     = 0;
          end
        end
      end else begin
        if (done) check_output("done_without_valid", 1, 0);
        if (gap_pending) gap_cnt++;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int x, base, n, cnt4, oa_cnt, ob_cnt, viol, done_at, bad_done;
    x = 1;
    for (int i = 0; i < LEN; i++) begin
      seq[i] = x;
      x = next_lfsr(x);
    end

    #1;
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_out_a", out_a, 0);
    check_output("rst_out_b", out_b, 0);
    check_output("rst_done", done, 0);
    #12 rst_n = 1'b1;
    @(negedge clk);

    apply_stimulus(128, 64);
    wait_drain();
    apply_stimulus(0, 255);
    wait_drain();

    stall_mode = 1'b1;
    apply_stimulus(128, 64);
    wait_drain();
    stall_mode = 1'b0;

    for (int i = 0; i < 4; i++) begin
      stall_mode = (i % 2 == 1);
      apply_stimulus($urandom_range(0, 255), $urandom_range(0, 255));
      wait_drain();
    end
    stall_mode = 1'b0;
    @(negedge clk);

    // Back-to-back: second offer held while the first stream runs.
    apply_stimulus(200, 37);
    apply_stimulus(90, 91);
    wait_drain();
    check_output("b2b_gap", last_gap, 1);

    // Reset in the middle of a stream.
    base = valid_count;
    apply_stimulus(77, 150);
    n = 0;
    while (valid_count < base + 100 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_output("mid_bits_reached", valid_count - base, 100);
    #1 rst_n = 1'b0;
    #1;
    check_output("async_out_valid", out_valid, 0);
    check_output("async_out_a", out_a, 0);
    check_output("async_out_b", out_b, 0);
    check_output("async_done", done, 0);
    check_output("async_in_ready", in_ready, 1);
    exp_q.delete();
    desc_q.delete();
    ones_a = 0;
    ones_b = 0;
    gap_pending = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    base = valid_count;
    apply_stimulus(33, 250);
    wait_drain();
    @(negedge clk);
    check_output("post_reset_bits", valid_count - base, LEN);

    // Narrow instance: BW=4, stream of 15 bits.
    @(negedge clk);
    v4_valid = 1'b1;
    a4 = 4'd7;
    b4 = 4'd12;
    @(negedge clk);
    v4_valid = 1'b0;
    cnt4 = 0; oa_cnt = 0; ob_cnt = 0; viol = 0; done_at = -1; bad_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ov4) begin
        cnt4++;
        oa_cnt += oa4;
        ob_cnt += ob4;
        if (oa4 && !ob4) viol++;
        if (done4) done_at = cnt4;
      end else if (done4) begin
        bad_done++;
      end
    end
    check_output("bw4_valid_bits", cnt4, 15);
    check_output("bw4_ones_a", oa_cnt, 7);
    check_output("bw4_ones_b", ob_cnt, 12);
    check_output("bw4_corr_violations", viol, 0);
    check_output("bw4_done_index", done_at, 15);
    check_output("bw4_stray_done", bad_done, 0);

    check_output("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
